wbs_rgb_pwm: RTL and testbench
==============================

# wbs_rgb_pwm

Wishbone B4 pipelined slave driving the board RGB LED through three 8-bit PWM channels with an optional linear fade engine. It sits on the shared Wishbone bus as a peripheral and owns the led_r/led_g/led_b pins. It sequences per-channel brightness so that duty changes never glitch mid-period.

## Interface

Parameters: none.

- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; asynchronous assert, active-low (0 = reset).
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  4  word address.
- wb_sel_i  in  4  byte-lane select.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, valid with ack.
- wb_stall_o  out  1  tied 0.
- wb_ack_o  out  1  transfer acknowledge.
- led_r, led_g, led_b  out  1 each  PWM outputs, registered, active-high.

## Operation

- Register map (word address; all read back; writes honour wb_sel_i per byte):
  - 0x0 CTRL: [0] enable, [1] fade_en.
  - 0x1 PRESCALE: [15:0]; a PWM tick occurs every PRESCALE+1 clocks.
  - 0x2/0x3/0x4 TGT_R/G/B: [7:0] target duty.
  - 0x5 FADE_DIV: [15:0]; the fade steps once every FADE_DIV+1 PWM periods.
  - 0x6 STATUS (RO): [0] busy = any cur_x != tgt_x.
  - 0x7 CUR (RO): {8'h0, cur_b, cur_g, cur_r}.
  - 0x8–0xF: reads return 0; writes are ignored. Writes to 0x6/0x7 are ignored.
- Unused register bits read 0.
- Prescaler: 16-bit pre_cnt. A tick occurs when pre_cnt >= PRESCALE, and pre_cnt then clears; otherwise pre_cnt increments. The >= compare means lowering PRESCALE below pre_cnt causes a tick on the next cycle.
- PWM counter: 8-bit pwm_cnt advances on each tick and wraps 255 -> 0. A period boundary is a tick with pwm_cnt = 255.
- Output: led_x <= enable & (pwm_cnt < cur_x).
  - cur = 0: LED constantly off.
  - cur = 255: LED on 255 of 256 ticks.
- cur_x is updated only at a period boundary:
  - fade_en = 0: cur_x <= tgt_x.
  - fade_en = 1: fade_cnt increments each boundary. When fade_cnt = FADE_DIV, fade_cnt clears and each cur_x moves 1 step toward tgt_x (+1, -1, or hold). There is no overshoot.
- enable = 0:
  - pre_cnt, pwm_cnt and fade_cnt are held at 0.
  - cur_x is frozen.
  - LEDs are 0 from the next cycle.
  - On re-enable, counting restarts from 0.
- Fade state machine per channel: IDLE (cur = tgt) / UP (cur < tgt) / DOWN (cur > tgt). The state is evaluated at the step instant.

## Timing

- Reset (wb_rst_i = 0, async): all registers, counters and cur_x clear to 0. wb_ack_o, wb_dat_o and the LEDs are 0. Reset mid-period aborts the period and mid-fade aborts the fade; after release, nothing restarts until CTRL is written.
- Bus:
  - wb_ack_o is asserted the cycle after cyc & stb, one ack per strobe; back-to-back strobes are accepted every cycle.
  - wb_dat_o is registered with the ack and is 0 when no ack.
  - Register writes take effect on the clock edge that raises ack.
- Simultaneous events:
  - A TGT write on a boundary cycle: the boundary uses the old tgt, and the new value applies at the next boundary.
  - A CTRL write clearing enable on a boundary cycle: that cycle's cur update still happens.
- LED latency: 1 clock from pwm_cnt/cur change to pin.
- PWM period is 256 × (PRESCALE+1) clocks.

## Test plan

- Reset / readback: hold wb_rst_i = 0 mid-run.
  - Required: LEDs, ack and dat_o read 0 immediately.
  - After release, write 0x2 = 0xA5 and read it back: ack 1 cycle later with 0x000000A5; 0x9 reads 0.
- Duty: PRESCALE = 0, TGT_R = 64, CTRL = 1.
  - Required: from the second boundary on, led_r is high exactly 64 of every 256 clocks.
  - TGT = 0 gives a constant low; TGT = 255 gives 255 high of 256.
- Glitch-free update: write TGT_G = 200 mid-period.
  - Required: CUR[15:8] and the led_g duty change only after the next boundary.
- Fade: PRESCALE = 0, FADE_DIV = 1, fade_en = 1, cur_b = 0, TGT_B = 3.
  - Required: cur_b increments every 512 clocks, reaching 3 after 1536 clocks; busy then drops to 0.
  - Then set TGT_B = 1: required to step down to 1 and stop.
- Byte select: write 0x1 with dat = 0xBEEF1234 and sel = 4'b0001 over a PRESCALE value of 0.
  - Required: PRESCALE reads 0x0034.
- Disable: clear enable mid-fade.
  - Required: LEDs 0 on the next cycle and CUR frozen.
  - On re-enable, the fade resumes from the frozen value with pwm_cnt starting at 0.

Source files
------------

// File: rtl/wbs_rgb_pwm.sv
// Wishbone B4 pipelined slave driving an RGB LED through three 8-bit PWM channels.
// Duty updates land only on period boundaries, optionally ramped by a linear fade engine.
module wbs_rgb_pwm (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b
);

  localparam logic [3:0] AdrCtrl     = 4'h0;
  localparam logic [3:0] AdrPrescale = 4'h1;
  localparam logic [3:0] AdrTgtR     = 4'h2;
  localparam logic [3:0] AdrTgtG     = 4'h3;
  localparam logic [3:0] AdrTgtB     = 4'h4;
  localparam logic [3:0] AdrFadeDiv  = 4'h5;
  localparam logic [3:0] AdrStatus   = 4'h6;
  localparam logic [3:0] AdrCur      = 4'h7;

  localparam logic [1:0] FadeIdle = 2'd0;
  localparam logic [1:0] FadeUp   = 2'd1;
  localparam logic [1:0] FadeDown = 2'd2;

  logic            enable_q, enable_d;
  logic            fade_en_q, fade_en_d;
  logic [15:0]     prescale_q, prescale_d;
  logic [15:0]     fade_div_q, fade_div_d;
  logic [2:0][7:0] tgt_q, tgt_d;
  logic [2:0][7:0] cur_q, cur_d;
  logic [15:0]     pre_cnt_q, pre_cnt_d;
  logic [7:0]      pwm_cnt_q, pwm_cnt_d;
  logic [15:0]     fade_cnt_q, fade_cnt_d;
  logic [2:0]      led_q, led_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;

  logic        req;
  logic        wr;
  logic        busy;
  logic        tick;
  logic        boundary;
  logic        step;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        unused_wdata;

  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [1:0] fade_state(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) begin
      return FadeUp;
    end else if (cur > tgt) begin
      return FadeDown;
    end
    return FadeIdle;
  endfunction

  function automatic logic [7:0] fade_next(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] res;
    case (fade_state(cur, tgt))
      FadeUp:   res = cur + 8'd1;
      FadeDown: res = cur - 8'd1;
      default:  res = cur;
    endcase
    return res;
  endfunction

  assign req  = wb_cyc_i & wb_stb_i;
  assign wr   = req & wb_we_i;
  assign busy = (cur_q != tgt_q);

  // Read mux doubles as the old value for byte-lane merging on writes.
  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      AdrCtrl:     rdata = {30'd0, fade_en_q, enable_q};
      AdrPrescale: rdata = {16'd0, prescale_q};
      AdrTgtR:     rdata = {24'd0, tgt_q[0]};
      AdrTgtG:     rdata = {24'd0, tgt_q[1]};
      AdrTgtB:     rdata = {24'd0, tgt_q[2]};
      AdrFadeDiv:  rdata = {16'd0, fade_div_q};
      AdrStatus:   rdata = {31'd0, busy};
      AdrCur:      rdata = {8'h00, cur_q[2], cur_q[1], cur_q[0]};
      default:     rdata = '0;
    endcase
  end

  assign wdata        = apply_sel(rdata, wb_dat_i, wb_sel_i);
  assign unused_wdata = ^wdata[31:16];

  always_comb begin
    enable_d   = enable_q;
    fade_en_d  = fade_en_q;
    prescale_d = prescale_q;
    fade_div_d = fade_div_q;
    tgt_d      = tgt_q;
    if (wr) begin
      case (wb_adr_i)
        AdrCtrl:     {fade_en_d, enable_d} = wdata[1:0];
        AdrPrescale: prescale_d = wdata[15:0];
        AdrTgtR:     tgt_d[0] = wdata[7:0];
        AdrTgtG:     tgt_d[1] = wdata[7:0];
        AdrTgtB:     tgt_d[2] = wdata[7:0];
        AdrFadeDiv:  fade_div_d = wdata[15:0];
        default:     ;
      endcase
    end
  end

  // The >= compare lets a lowered PRESCALE take effect on the very next cycle.
  assign tick     = enable_q & (pre_cnt_q >= prescale_q);
  assign boundary = tick & (pwm_cnt_q == 8'hFF);
  assign step     = boundary & fade_en_q & (fade_cnt_q == fade_div_q);

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    fade_cnt_d = fade_cnt_q;
    cur_d      = cur_q;
    if (!enable_q) begin
      pre_cnt_d  = '0;
      pwm_cnt_d  = '0;
      fade_cnt_d = '0;
    end else begin
      if (tick) begin
        pre_cnt_d = '0;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
      end else begin
        pre_cnt_d = pre_cnt_q + 16'd1;
      end
      if (!fade_en_q) begin
        fade_cnt_d = '0;
      end else if (boundary) begin
        fade_cnt_d = step ? 16'd0 : fade_cnt_q + 16'd1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (boundary && !fade_en_q) begin
        cur_d[i] = tgt_q[i];
      end else if (step) begin
        cur_d[i] = fade_next(cur_q[i], tgt_q[i]);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      led_d[i] = enable_q & (pwm_cnt_q < cur_q[i]);
    end
    ack_d = req;
    dat_d = (req & ~wb_we_i) ? rdata : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      enable_q   <= 1'b0;
      fade_en_q  <= 1'b0;
      prescale_q <= '0;
      fade_div_q <= '0;
      tgt_q      <= '0;
      cur_q      <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
      led_q      <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      enable_q   <= enable_d;
      fade_en_q  <= fade_en_d;
      prescale_q <= prescale_d;
      fade_div_q <= fade_div_d;
      tgt_q      <= tgt_d;
      cur_q      <= cur_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      led_q      <= led_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_stall_o = 1'b0;
  assign led_r      = led_q[0];
  assign led_g      = led_q[1];
  assign led_b      = led_q[2];

endmodule

// File: tb/tb_wbs_rgb_pwm.sv
// Self-checking bench for wbs_rgb_pwm: directed scenarios plus random bus traffic,
// every cycle compared against a behavioural model of the register/PWM/fade rules.
module tb_wbs_rgb_pwm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic        stall;
  logic        ack;
  logic        led_r;
  logic        led_g;
  logic        led_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wbs_rgb_pwm dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_adr_i  (adr),
    .wb_sel_i  (sel),
    .wb_dat_i  (wdat),
    .wb_dat_o  (rdat),
    .wb_stall_o(stall),
    .wb_ack_o  (ack),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: integer state updated once per clock from the register rules.
  bit          m_en = 1'b0;
  bit          m_fe = 1'b0;
  int          m_pre = 0;
  int          m_div = 0;
  int          m_tgt[3] = '{0, 0, 0};
  int          m_cur[3] = '{0, 0, 0};
  int          m_pc = 0;
  int          m_pwm = 0;
  int          m_fc = 0;
  bit [2:0]    m_led = '0;
  bit          m_ack = 1'b0;
  logic [31:0] m_dat = '0;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'h0: return {30'd0, m_fe, m_en};
      4'h1: return m_pre;
      4'h2: return m_tgt[0];
      4'h3: return m_tgt[1];
      4'h4: return m_tgt[2];
      4'h5: return m_div;
      4'h6: return (m_cur[0] != m_tgt[0] || m_cur[1] != m_tgt[1] || m_cur[2] != m_tgt[2]) ? 1 : 0;
      4'h7: return (m_cur[2] << 16) | (m_cur[1] << 8) | m_cur[0];
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_en = 0; m_fe = 0; m_pre = 0; m_div = 0; m_pc = 0; m_pwm = 0; m_fc = 0;
    for (int i = 0; i < 3; i++) begin
      m_tgt[i] = 0;
      m_cur[i] = 0;
    end
    m_led = '0; m_ack = 0; m_dat = '0;
  endtask

  task automatic model_clock();
    bit          tick;
    bit          bnd;
    logic [31:0] v;
    tick = m_en && (m_pc >= m_pre);
    bnd  = tick && (m_pwm == 255);
    for (int i = 0; i < 3; i++) m_led[i] = m_en && (m_pwm < m_cur[i]);
    m_ack = cyc && stb;
    m_dat = (cyc && stb && !we) ? m_read(adr) : 32'd0;
    if (bnd) begin
      if (!m_fe) begin
        for (int i = 0; i < 3; i++) m_cur[i] = m_tgt[i];
      end else if (m_fc == m_div) begin
        m_fc = 0;
        for (int i = 0; i < 3; i++)
          m_cur[i] += (m_tgt[i] > m_cur[i]) ? 1 : ((m_tgt[i] < m_cur[i]) ? -1 : 0);
      end else begin
        m_fc++;
      end
    end
    if (!m_en) begin
      m_pc = 0; m_pwm = 0; m_fc = 0;
    end else if (tick) begin
      m_pc = 0; m_pwm = (m_pwm + 1) % 256;
    end else begin
      m_pc++;
    end
    if (!m_fe) m_fc = 0;
    if (cyc && stb && we) begin
      v = merge(m_read(adr), wdat, sel);
      case (adr)
        4'h0: begin m_en = v[0]; m_fe = v[1]; end
        4'h1: m_pre = int'(v[15:0]);
        4'h2: m_tgt[0] = int'(v[7:0]);
        4'h3: m_tgt[1] = int'(v[7:0]);
        4'h4: m_tgt[2] = int'(v[7:0]);
        4'h5: m_div = int'(v[15:0]);
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_clock();
  end

  // Bus helpers: step() samples at the falling edge and compares, drive() sets inputs.
  task automatic step();
    @(negedge clk);
    check_eq("leds", {29'd0, led_b, led_g, led_r}, {29'd0, m_led});
    check_eq("ack", {31'd0, ack}, {31'd0, m_ack});
    check_eq("dat", rdat, m_dat);
    check_eq("stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic drive(input bit c, input bit w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    cyc = c; stb = c; we = w; adr = a; wdat = d; sel = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive(0, 0, 4'h0, 32'd0, 4'h0);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    step();
    drive(1, 1, a, d, s);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    step();
    drive(1, 0, a, 32'd0, 4'hF);
    step();
    check_eq("rd_ack", {31'd0, ack}, 32'd1);
    v = rdat;
    drive(0, 0, 4'h0, 32'd0, 4'h0);
  endtask

  task automatic count_high(input int ch, input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      step();
      h += (ch == 0) ? int'(led_r) : ((ch == 1) ? int'(led_g) : int'(led_b));
      drive(0, 0, 4'h0, 32'd0, 4'h0);
    end
  endtask

  // Issue a write on the clock edge that the model says is a period boundary.
  task automatic write_on_boundary(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    step();
    while (!(m_en && m_pc >= m_pre && m_pwm == 255) && n < 3000) begin
      drive(0, 0, 4'h0, 32'd0, 4'h0);
      step();
      n++;
    end
    check_eq("bnd_found", {31'd0, n < 3000}, 32'd1);
    drive(1, 1, a, d, 4'hF);
  endtask

  initial begin
    logic [31:0] v;
    int          h;
    int          n;
    logic [31:0] frozen;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Duty cycles
    wr(4'h1, 32'd0, 4'hF);
    wr(4'h2, 32'd64, 4'hF);
    wr(4'h0, 32'd1, 4'hF);
    idle(600);
    count_high(0, 256, h);
    check_eq("duty64", h, 64);
    wr(4'h2, 32'd0, 4'hF);
    idle(600);
    count_high(0, 256, h);
    check_eq("duty0", h, 0);
    wr(4'h2, 32'd255, 4'hF);
    idle(600);
    count_high(0, 256, h);
    check_eq("duty255", h, 255);

    // Asynchronous reset while an ack and LED are high
    step();
    drive(1, 0, 4'h2, 32'd0, 4'hF);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive(0, 0, 4'h0, 32'd0, 4'h0);
    #1;
    check_eq("rst_leds", {29'd0, led_b, led_g, led_r}, 32'd0);
    check_eq("rst_ack", {31'd0, ack}, 32'd0);
    check_eq("rst_dat", rdat, 32'd0);
    idle(4);
    rst_n = 1'b1;
    idle(300);
    wr(4'h2, 32'h0000_00A5, 4'hF);
    rd(4'h2, v);
    check_eq("tgt_r_rb", v, 32'h0000_00A5);
    rd(4'h9, v);
    check_eq("unmapped_rd", v, 32'd0);
    rd(4'h7, v);
    check_eq("cur_after_rst", v, 32'd0);

    // Byte-lane select
    wr(4'h1, 32'd0, 4'hF);
    wr(4'h1, 32'hBEEF_1234, 4'b0001);
    rd(4'h1, v);
    check_eq("bytesel", v, 32'h0000_0034);
    wr(4'h1, 32'd0, 4'hF);

    // Glitch-free duty update mid-period
    wr(4'h0, 32'd1, 4'hF);
    n = 0;
    while (m_pwm != 100 && n < 1000) begin
      idle(1);
      n++;
    end
    check_eq("mid_found", {31'd0, n < 1000}, 32'd1);
    wr(4'h3, 32'd200, 4'hF);
    rd(4'h7, v);
    check_eq("cur_g_hold", {24'd0, v[15:8]}, 32'd0);
    idle(300);
    rd(4'h7, v);
    check_eq("cur_g_new", {24'd0, v[15:8]}, 32'd200);
    count_high(1, 256, h);
    check_eq("duty200", h, 200);

    // Fade up by one step every two periods
    wr(4'h0, 32'd0, 4'hF);
    wr(4'h5, 32'd1, 4'hF);
    wr(4'h4, 32'd3, 4'hF);
    wr(4'h0, 32'd3, 4'hF);
    idle(700);
    rd(4'h7, v);
    check_eq("fade_b1", {24'd0, v[23:16]}, 32'd1);
    rd(4'h6, v);
    check_eq("busy1", v, 32'd1);
    idle(900);
    rd(4'h7, v);
    check_eq("fade_b3", {24'd0, v[23:16]}, 32'd3);
    rd(4'h6, v);
    check_eq("busy0", v, 32'd0);
    wr(4'h4, 32'd1, 4'hF);
    idle(1100);
    rd(4'h7, v);
    check_eq("fade_down", {24'd0, v[23:16]}, 32'd1);
    rd(4'h6, v);
    check_eq("busy0_down", v, 32'd0);

    // Disable mid-fade, then resume
    wr(4'h4, 32'd255, 4'hF);
    idle(1200);
    wr(4'h0, 32'd0, 4'hF);
    idle(2);
    check_eq("dis_leds", {29'd0, led_b, led_g, led_r}, 32'd0);
    frozen = (m_cur[2] << 16) | (m_cur[1] << 8) | m_cur[0];
    idle(1500);
    rd(4'h7, v);
    check_eq("cur_frozen", v, frozen);
    wr(4'h0, 32'd3, 4'hF);
    idle(1200);
    rd(4'h7, v);
    check_eq("fade_resume", {24'd0, v[23:16]}, {24'd0, frozen[23:16] + 8'd2});

    // Writes landing exactly on a period boundary
    wr(4'h0, 32'd1, 4'hF);
    wr(4'h1, 32'd1, 4'hF);
    idle(1100);
    write_on_boundary(4'h2, 32'h11);
    rd(4'h7, v);
    check_eq("bnd_old_tgt", {24'd0, v[7:0]}, 32'hA5);
    idle(1100);
    rd(4'h7, v);
    check_eq("bnd_new_tgt", {24'd0, v[7:0]}, 32'h11);
    wr(4'h2, 32'h22, 4'hF);
    write_on_boundary(4'h0, 32'd0);
    idle(600);
    rd(4'h7, v);
    check_eq("bnd_disable", {24'd0, v[7:0]}, 32'h22);

    // Random traffic
    wr(4'h1, 32'd0, 4'hF);
    wr(4'h0, 32'd1, 4'hF);
    for (int i = 0; i < 6000; i++) begin
      int          r;
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      r = $urandom_range(0, 63);
      a = 4'($urandom_range(0, 15));
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      d = $urandom;
      if (a == 4'h1) d = $urandom_range(0, 3);
      if (a == 4'h5) d = $urandom_range(0, 2);
      step();
      if (r == 0) drive(1, 1, a, d, s);
      else if (r < 4) drive(1, 0, a, 32'd0, 4'hF);
      else drive(0, 0, 4'h0, 32'd0, 4'h0);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
